isp_dram_rd_sched: RTL

//  Read scheduler between the ISP command front end and the pseudo-DRAM AXI4 read channel.
//  On a start pulse (pic_no, mode), issues one INCR burst per colour channel (R, G, B, in that order).

---
 rtl/isp_dram_rd_sched_if.sv | 40 ++++
 rtl/isp_dram_rd_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/isp_dram_rd_sched_if.sv
// isp_dram_rd_sched_if: AXI4 read address/data channel plus tagged pixel stream.
// master = scheduler side, slave = pseudo-DRAM / datapath side.
interface isp_dram_rd_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [1:0]        pix_ch;
  logic [4:0]        pix_row;
  logic              pix_half;

  modport master (
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output pix_valid, pix_data, pix_ch, pix_row, pix_half,
    input  pix_ready
  );

  modport slave (
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  pix_valid, pix_data, pix_ch, pix_row, pix_half,
    output pix_ready
  );
endinterface

// File: rtl/isp_dram_rd_sched.sv
// isp_dram_rd_sched: issues one read burst per colour channel (R, G, B)
// and forwards the returned beats tagged with channel/row/half.
module isp_dram_rd_sched #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 128,
  parameter int unsigned BASE_ADDR  = 32'h10000,
  parameter int          IMG_DIM    = 32,
  parameter int          FOCUS_ROW0 = 13,
  parameter int          FOCUS_ROWS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] pic_no,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  isp_dram_rd_sched_if.master bus
);

  localparam int BPB       = DATA_W / 8;
  localparam int BPR       = IMG_DIM / BPB;
  localparam int CH_BYTES  = IMG_DIM * IMG_DIM;
  localparam int PIC_BYTES = 3 * CH_BYTES;
  localparam int FULL_LEN  = IMG_DIM * IMG_DIM / BPB - 1;
  localparam int FOCUS_LEN = FOCUS_ROWS * IMG_DIM / BPB - 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state, state_d;

  logic [3:0] pic_q;
  logic       mode_q;
  logic [1:0] ch;
  logic [7:0] beat;
  logic [4:0] row0;

  logic acc;
  logic ar_fire;
  logic r_fire;
  logic last_beat;
  logic end_burst;
  logic bad;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [3:0] p,
    input logic       m,
    input logic [1:0] c
  );
    logic [ADDR_W-1:0] r;
    r = m ? '0 : ADDR_W'(FOCUS_ROW0);
    return ADDR_W'(BASE_ADDR)
         + ADDR_W'(p) * ADDR_W'(PIC_BYTES)
         + ADDR_W'(c) * ADDR_W'(CH_BYTES)
         + r * ADDR_W'(IMG_DIM);
  endfunction

  function automatic logic [7:0] len_of(input logic m);
    return m ? 8'(FULL_LEN) : 8'(FOCUS_LEN);
  endfunction

  // state register; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next state, handshake decode and status outputs
  always_comb begin
    state_d       = state;
    acc           = 1'b0;
    ar_fire       = 1'b0;
    r_fire        = 1'b0;
    last_beat     = 1'b0;
    end_burst     = 1'b0;
    bad           = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.pix_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc     = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        busy        = 1'b1;
        bus.arvalid = 1'b1;
        if (bus.arready) begin
          ar_fire = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        busy          = 1'b1;
        bus.rready    = bus.pix_ready;
        bus.pix_valid = bus.rvalid;
        r_fire        = bus.rvalid && bus.pix_ready;
        last_beat     = (beat == bus.arlen);
        if (r_fire) begin
          end_burst = last_beat || bus.rlast;
          bad = (bus.rresp != 2'b00)
              || (bus.rlast && !last_beat)
              || (!bus.rlast && last_beat);
          if (end_burst) state_d = (ch == 2'd2) ? DONE : ADDR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch, burst address/length, channel and beat counters, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pic_q      <= '0;
      mode_q     <= 1'b0;
      ch         <= '0;
      beat       <= '0;
      err        <= 1'b0;
      bus.araddr <= '0;
      bus.arlen  <= '0;
    end else begin
      if (acc) begin
        pic_q      <= pic_no;
        mode_q     <= mode;
        ch         <= '0;
        err        <= 1'b0;
        bus.araddr <= addr_of(pic_no, mode, 2'd0);
        bus.arlen  <= len_of(mode);
      end
      if (ar_fire) beat <= '0;
      if (r_fire) begin
        beat <= beat + 8'd1;
        if (bad) err <= 1'b1;
        if (end_burst && ch != 2'd2) begin
          ch         <= ch + 2'd1;
          bus.araddr <= addr_of(pic_q, mode_q, ch + 2'd1);
        end
      end
    end
  end

  assign row0         = mode_q ? 5'd0 : 5'(FOCUS_ROW0);
  assign bus.pix_data = bus.rdata;
  assign bus.pix_ch   = ch;
  assign bus.pix_row  = row0 + 5'(beat / 8'(BPR));
  assign bus.pix_half = 1'(beat % 8'(BPR));

endmodule
